// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi: NUM_CH-lane two-stage TMDS/TERC4 encoder with per-lane running disparity.
// Define TMDS_DISP_MON_EN to add the disp_out / disp_err_out disparity monitor.
module tmds_encoder_multi #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [2:0]            mode_in,
  input  logic [8*NUM_CH-1:0]   data_in,
  input  logic [2*NUM_CH-1:0]   ctrl_in,
  input  logic [4*NUM_CH-1:0]   aux_in,
  output logic [10*NUM_CH-1:0]  tmds_out
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [CNT_W*NUM_CH-1:0] disp_out,
  output logic                    disp_err_out
`endif
);
  localparam logic [9:0] GB_EVEN = 10'b1011001100;
  localparam logic [9:0] GB_ODD = 10'b0100110011;
  localparam logic [9:0] CTRL_SYM [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  function automatic logic [8:0] qm_f(input logic [7:0] d);
    logic [8:0] q;
    logic x;
    x = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
    q[8] = ~x;
    return q;
  endfunction
  // returns {symbol, next counter}; bal is n1-n0 over q[7:0]
  function automatic logic [9+CNT_W:0] video(input logic [8:0] q, input logic signed [CNT_W-1:0] c);
    logic signed [CNT_W-1:0] bal, tq, dq;
    logic eq, inv;
    bal = CNT_W'(2 * $countones(q[7:0]) - 8);
    tq = q[8] ? CNT_W'(2) : '0;
    dq = q[8] ? '0 : CNT_W'(2);
    eq = c == '0 || bal == '0;
    inv = eq ? ~q[8] : c[CNT_W-1] == bal[CNT_W-1];
    return {inv, q[8], inv ? ~q[7:0] : q[7:0],
            eq ? (q[8] ? c + bal : c - bal) : inv ? c + tq - bal : c + bal - dq};
  endfunction
  logic                      v1;
  logic [2:0]                mode1;
  logic [2*NUM_CH-1:0]       ctrl1;
  logic [4*NUM_CH-1:2]       aux1;
  logic [9*NUM_CH-1:0]       qm1, qm_n;
  logic [10*NUM_CH-1:0]      sym_n;
  logic [CNT_W*NUM_CH-1:0]   cnt, cnt_n;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [3:0]         nib;
    logic [9:0]         ig;
    logic [9+CNT_W:0]   vid;
    if (k == 0) begin : g_l0
      assign nib = {aux1[3:2], ctrl1[1:0]};
      assign ig = TERC4[{2'b11, ctrl1[1:0]}];
    end else begin : g_ln
      assign nib = aux1[4*k +: 4];
      assign ig = GB_ODD;
    end
    assign qm_n[9*k +: 9] = qm_f(data_in[8*k +: 8]);
    assign vid = video(qm1[9*k +: 9], $signed(cnt[CNT_W*k +: CNT_W]));
    assign sym_n[10*k +: 10] = !v1 ? '0 :
                               mode1 == 3'd1 ? vid[9+CNT_W:CNT_W] :
                               mode1 == 3'd2 ? (k % 2 == 1 ? GB_ODD : GB_EVEN) :
                               mode1 == 3'd3 ? ig :
                               mode1 == 3'd4 ? TERC4[nib] :
                               CTRL_SYM[ctrl1[2*k +: 2]];
    assign cnt_n[CNT_W*k +: CNT_W] = v1 && mode1 == 3'd1 ? vid[CNT_W-1:0] : '0;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1 <= 1'b0;
      mode1 <= '0;
      ctrl1 <= '0;
      aux1 <= '0;
      qm1 <= '0;
      tmds_out <= '0;
      cnt <= '0;
    end else begin
      v1 <= 1'b1;
      mode1 <= mode_in;
      ctrl1 <= ctrl_in;
      aux1 <= aux_in[4*NUM_CH-1:2];
      qm1 <= qm_n;
      tmds_out <= sym_n;
      cnt <= cnt_n;
    end
  end
`ifdef TMDS_DISP_MON_EN
  logic [NUM_CH-1:0] over;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_mon
    assign over[k] = int'($signed(cnt_n[CNT_W*k +: CNT_W])) > 16 || int'($signed(cnt_n[CNT_W*k +: CNT_W])) < -16;
  end
  assign disp_out = cnt;
  always_ff @(posedge clk_in) disp_err_out <= rst_in ? 1'b0 : disp_err_out | (|over);
`endif
endmodule

// File: tb/tb_tmds_encoder_multi.sv
// tb_tmds_encoder_multi: scoreboard bench for tmds_encoder_multi (NUM_CH=3), expected symbols from a spec-level model.
module tb_tmds_encoder_multi;
  localparam int NUM_CH = 3;
  localparam int CNT_W = 5;
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  localparam logic [9:0] CSYM [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  typedef struct {
    logic [10*NUM_CH-1:0]    sym;
    logic [CNT_W*NUM_CH-1:0] disp;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [2:0] mode_in = '0;
  logic [8*NUM_CH-1:0] data_in = '0;
  logic [2*NUM_CH-1:0] ctrl_in = '0;
  logic [4*NUM_CH-1:0] aux_in = '0;
  logic [10*NUM_CH-1:0] tmds_out;
`ifdef TMDS_DISP_MON_EN
  logic [CNT_W*NUM_CH-1:0] disp_out;
  logic disp_err_out;
`endif
  exp_t sb[$];
  logic signed [CNT_W-1:0] mcnt [NUM_CH];
  int n_cmp = 0;
  int n_err = 0;
  tmds_encoder_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .mode_in(mode_in),
    .data_in(data_in),
    .ctrl_in(ctrl_in),
    .aux_in(aux_in),
    .tmds_out(tmds_out)
`ifdef TMDS_DISP_MON_EN
    ,
    .disp_out(disp_out),
    .disp_err_out(disp_err_out)
`endif
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic [2:0] m, input logic [8*NUM_CH-1:0] d,
                       input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] a);
    exp_t e;
    logic [7:0] db, q;
    logic xn;
    int c_i, n1, qm8;
    @(negedge clk_in);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("tmds_out", 64'(tmds_out), 64'(e.sym));
`ifdef TMDS_DISP_MON_EN
      check("disp_out", 64'(disp_out), 64'(e.disp));
      check("disp_err", 64'(disp_err_out), 64'(0));
`endif
    end
    rst_in = r; mode_in = m; data_in = d; ctrl_in = c; aux_in = a;
    e.sym = '0;
    e.disp = '0;
    if (r) begin
      if (sb.size() != 0) begin
        void'(sb.pop_back());
        sb.push_back(e);
      end
      for (int k = 0; k < NUM_CH; k++) mcnt[k] = '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (m == 3'd1) begin
          db = d[8*k +: 8];
          xn = $countones(db) > 4 || ($countones(db) == 4 && db[0] == 1'b0);
          q[0] = db[0];
          for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ db[i]) : (q[i-1] ^ db[i]);
          qm8 = xn ? 0 : 1;
          n1 = $countones(q);
          c_i = mcnt[k];
          if (c_i == 0 || n1 == 8 - n1) begin
            e.sym[10*k +: 10] = {~qm8[0], qm8[0], qm8 == 1 ? q : ~q};
            c_i += qm8 == 1 ? n1 - (8 - n1) : (8 - n1) - n1;
          end else if ((c_i > 0 && n1 > 8 - n1) || (c_i < 0 && 8 - n1 > n1)) begin
            e.sym[10*k +: 10] = {1'b1, qm8[0], ~q};
            c_i += 2 * qm8 + (8 - n1) - n1;
          end else begin
            e.sym[10*k +: 10] = {1'b0, qm8[0], q};
            c_i += -2 * (1 - qm8) + n1 - (8 - n1);
          end
          mcnt[k] = c_i[CNT_W-1:0];
        end else begin
          mcnt[k] = '0;
          e.sym[10*k +: 10] = m == 3'd2 ? (k % 2 == 1 ? 10'b0100110011 : 10'b1011001100) :
                              m == 3'd3 ? (k == 0 ? TERC[{2'b11, c[1:0]}] : 10'b0100110011) :
                              m == 3'd4 ? (k == 0 ? TERC[{a[3:2], c[1:0]}] : TERC[a[4*k +: 4]]) :
                              CSYM[c[2*k +: 2]];
        end
        e.disp[CNT_W*k +: CNT_W] = mcnt[k];
      end
    end
    sb.push_back(e);
  endtask
  initial begin
    for (int k = 0; k < NUM_CH; k++) mcnt[k] = '0;
    repeat (2) drive(1'b1, 3'd0, '0, '0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 24'($urandom), {4'(i * 5), 2'(i)}, '0);
    drive(1'b0, 3'd1, 24'h000000, '0, '0);
    drive(1'b0, 3'd1, 24'h000000, '0, '0);
    drive(1'b0, 3'd0, '0, '0, '0);
    drive(1'b0, 3'd1, 24'hFFFFFF, '0, '0);
    drive(1'b0, 3'd1, 24'h000000, '0, '0);
    drive(1'b0, 3'd1, 24'h000000, '0, '0);
    drive(1'b0, 3'd2, 24'($urandom), 6'($urandom), 12'($urandom));
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd3, 24'($urandom), 6'(i), 12'($urandom));
    drive(1'b0, 3'd4, '0, 6'b000001, 12'h358);
    drive(1'b0, 3'd4, '0, 6'b000011, 12'hFA7);
    for (int i = 5; i < 8; i++) drive(1'b0, 3'(i), 24'($urandom), 6'($urandom), 12'($urandom));
    for (int i = 0; i < 6; i++) drive(1'b0, 3'd1, 24'($urandom), '0, '0);
    drive(1'b1, 3'd1, 24'($urandom), '0, '0);
    for (int i = 0; i < 6; i++) drive(1'b0, 3'd1, 24'($urandom), '0, '0);
    for (int i = 0; i < 1000; i++) drive(1'b0, 3'd1, 24'($urandom), '0, '0);
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 5) < 3 ? 3'd1 : 3'($urandom),
            24'($urandom), 6'($urandom), 12'($urandom));
    repeat (3) drive(1'b0, 3'd0, '0, '0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
